// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - ALU opcodes, widths and sequencer state encoding
package alu_cmd_sequencer_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OP_W-1:0] OP_NOT_A = 4'd1;
    localparam logic [OP_W-1:0] OP_AND   = 4'd2;
    localparam logic [OP_W-1:0] OP_OR    = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
    localparam logic [OP_W-1:0] OP_XNOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_ADD   = 4'd6;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WB
    } seq_state_t;

    // Codes 8..15 are illegal
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return !op[OP_W-1];
    endfunction

    function automatic logic op_writes(input logic [OP_W-1:0] op);
        return op_legal(op) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREG x 32 register file, two async read ports, host and write-back ports
module alu_regfile
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra_addr,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              hw_en,
    input  logic [AW-1:0]     hw_addr,
    input  logic [DATA_W-1:0] hw_data,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] regs [NREG];

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

    // Write-back beats a same-cycle host write to the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_en && (wb_addr == AW'(i))) begin
                    regs[i] <= wb_data;
                end else if (hw_en && (hw_addr == AW'(i))) begin
                    regs[i] <= hw_data;
                end
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - ALU command sequencer; ALU_STATUS_FLAGS_EN adds flag_z/flag_n
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [AW-1:0]     cmd_ra,
    input  logic [AW-1:0]     cmd_rb,
    input  logic [AW-1:0]     cmd_rd,
    input  logic              hw_en,
    input  logic [AW-1:0]     hw_addr,
    input  logic [DATA_W-1:0] hw_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [63:0]       alu_result,
`ifdef ALU_STATUS_FLAGS_EN
    output logic              flag_z,
    output logic              flag_n,
`endif
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rsp_data
);

    seq_state_t        state;
    logic [OP_W-1:0]   lat_op;
    logic [AW-1:0]     lat_ra;
    logic [AW-1:0]     lat_rb;
    logic [AW-1:0]     lat_rd;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              wb_en;
    logic              unused_result_hi;

    assign unused_result_hi = ^alu_result[63:32];
    assign wb_en            = (state == S_WB) && op_writes(lat_op);

    alu_regfile #(
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (lat_ra),
        .rb_addr (lat_rb),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .hw_en   (hw_en),
        .hw_addr (hw_addr),
        .hw_data (hw_data),
        .wb_en   (wb_en),
        .wb_addr (lat_rd),
        .wb_data (res)
    );

    // done/err/rsp_data are set on the CAPTURE->WB edge so they are visible in the WB cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            lat_op    <= OP_NOP;
            lat_ra    <= '0;
            lat_rb    <= '0;
            lat_rd    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OP_NOP;
            res       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rsp_data  <= '0;
`ifdef ALU_STATUS_FLAGS_EN
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        lat_op    <= cmd_op;
                        lat_ra    <= cmd_ra;
                        lat_rb    <= cmd_rb;
                        lat_rd    <= cmd_rd;
                        cmd_ready <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_a  <= ra_data;
                    alu_b  <= rb_data;
                    alu_op <= op_legal(lat_op) ? lat_op : OP_NOP;
                    state  <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    res  <= alu_result[DATA_W-1:0];
                    done <= 1'b1;
                    err  <= !op_legal(lat_op);
                    if (op_writes(lat_op)) begin
                        rsp_data <= alu_result[DATA_W-1:0];
`ifdef ALU_STATUS_FLAGS_EN
                        flag_z   <= (alu_result[DATA_W-1:0] == '0);
                        flag_n   <= alu_result[DATA_W-1];
`endif
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a stub ALU
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [2:0]  cmd_ra = '0;
    logic [2:0]  cmd_rb = '0;
    logic [2:0]  cmd_rd = '0;
    logic        hw_en = 1'b0;
    logic [2:0]  hw_addr = '0;
    logic [31:0] hw_data = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_result;
    logic [31:0] alu_hi = '0;
    logic        done;
    logic        err;
    logic [31:0] rsp_data;
`ifdef ALU_STATUS_FLAGS_EN
    logic        flag_z;
    logic        flag_n;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_r [8];
    logic [31:0] ref_rsp;
    logic        ref_z;
    logic        ref_n;

    logic [3:0]  nxt_op;
    logic [2:0]  nxt_ra, nxt_rb, nxt_rd;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_ra     (cmd_ra),
        .cmd_rb     (cmd_rb),
        .cmd_rd     (cmd_rd),
        .hw_en      (hw_en),
        .hw_addr    (hw_addr),
        .hw_data    (hw_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
`ifdef ALU_STATUS_FLAGS_EN
        .flag_z     (flag_z),
        .flag_n     (flag_n),
`endif
        .done       (done),
        .err        (err),
        .rsp_data   (rsp_data)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:    return ~a;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a ^ b);
            4'd6:    return a + b;
            4'd7:    return a - b;
            default: return 32'd0;
        endcase
    endfunction

    // Upper result half is random garbage the sequencer must ignore
    always @(posedge clk) alu_hi <= $urandom;
    always_comb alu_result = {alu_hi, alu_fn(alu_op, alu_a, alu_b)};

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_r[i] = '0;
        ref_rsp = '0;
        ref_z   = 1'b0;
        ref_n   = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.u_regfile.regs[i] !== ref_r[i]) begin
                failures++;
                $display("FAIL %s R%0d got=%h exp=%h", tag, i, dut.u_regfile.regs[i], ref_r[i]);
            end
        end
    endtask

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        hw_en = 1'b1; hw_addr = a; hw_data = d;
        @(posedge clk); #1;
        hw_en = 1'b0;
        ref_r[a] = d;
    endtask

    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [2:0] ra,
                          input logic [2:0] rb, input logic [2:0] rd, input bit collide,
                          input logic [31:0] cdata, input bit hold, output int waits);
        logic [31:0] exp;
        bit wr, ill;
        int lat;
        waits = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
        while (cmd_ready !== 1'b1 && waits < 8) begin
            @(posedge clk); #1;
            waits++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept_timeout cmd_ready=%b exp=1", tag, cmd_ready);
        end
        ill = (op >= 4'd8);
        wr  = !ill && (op != 4'd0);
        exp = wr ? alu_fn(op, ref_r[ra], ref_r[rb]) : ref_rsp;
        @(posedge clk); #1;
        if (hold) begin
            cmd_op = nxt_op; cmd_ra = nxt_ra; cmd_rb = nxt_rb; cmd_rd = nxt_rd;
        end else begin
            cmd_valid = 1'b0;
        end
        lat = 1;
        while (done !== 1'b1 && lat < 6) begin
            checks++;
            if (cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s busy_ready lat=%0d got=%b exp=0", tag, lat, cmd_ready);
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 3 || done !== 1'b1) begin
            failures++;
            $display("FAIL %s latency got=%0d done=%b exp=3", tag, lat, done);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s wb_ready got=%b exp=0", tag, cmd_ready);
        end
        checks++;
        if (err !== ill) begin
            failures++;
            $display("FAIL %s err got=%b exp=%b", tag, err, ill);
        end
        checks++;
        if (rsp_data !== exp) begin
            failures++;
            $display("FAIL %s rsp_data got=%h exp=%h", tag, rsp_data, exp);
        end
        if (wr) begin
            ref_rsp = exp;
            ref_z   = (exp == 32'd0);
            ref_n   = exp[31];
        end
`ifdef ALU_STATUS_FLAGS_EN
        checks++;
        if (flag_z !== ref_z || flag_n !== ref_n) begin
            failures++;
            $display("FAIL %s flags got=%b%b exp=%b%b", tag, flag_z, flag_n, ref_z, ref_n);
        end
`endif
        if (collide) begin
            hw_en = 1'b1; hw_addr = rd; hw_data = cdata;
            ref_r[rd] = cdata;
        end
        if (wr) ref_r[rd] = exp;
        @(posedge clk); #1;
        hw_en = 1'b0;
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s post_wb done=%b ready=%b exp=0/1", tag, done, cmd_ready);
        end
        check_regs(tag);
    endtask

    task automatic test_reset();
        int w;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got ready=%b done=%b err=%b exp=1/0/0", cmd_ready, done, err);
        end
        checks++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== OP_NOP || rsp_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got a=%h b=%h op=%h rsp=%h exp=0", alu_a, alu_b, alu_op, rsp_data);
        end
        check_regs("reset");
        w = 0;
    endtask

    task automatic test_add();
        int w;
        host_write(3'd1, 32'd5);
        host_write(3'd2, 32'd3);
        do_cmd("add", OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 32'd0, 1'b0, w);
        checks++;
        if (rsp_data !== 32'd8) begin
            failures++;
            $display("FAIL add_value got=%h exp=00000008", rsp_data);
        end
    endtask

    task automatic test_sub_wrap();
        int w;
        host_write(3'd1, 32'd0);
        host_write(3'd2, 32'd1);
        do_cmd("sub_wrap", OP_SUB, 3'd1, 3'd2, 3'd4, 1'b0, 32'd0, 1'b0, w);
        checks++;
        if (rsp_data !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL sub_wrap_value got=%h exp=ffffffff", rsp_data);
        end
    endtask

    task automatic test_illegal();
        int w;
        do_cmd("illegal", 4'b1010, 3'd1, 3'd2, 3'd3, 1'b0, 32'd0, 1'b0, w);
        do_cmd("nop", OP_NOP, 3'd2, 3'd1, 3'd4, 1'b0, 32'd0, 1'b0, w);
    endtask

    task automatic test_back_to_back();
        int w;
        host_write(3'd5, 32'hA5A5_A5A5);
        nxt_op = OP_OR; nxt_ra = 3'd3; nxt_rb = 3'd4; nxt_rd = 3'd0;
        do_cmd("xor_self", OP_XOR, 3'd5, 3'd5, 3'd5, 1'b0, 32'd0, 1'b1, w);
        do_cmd("held_cmd", nxt_op, nxt_ra, nxt_rb, nxt_rd, 1'b0, 32'd0, 1'b0, w);
        checks++;
        if (w != 0) begin
            failures++;
            $display("FAIL held_accept_wait got=%0d exp=0", w);
        end
    endtask

    task automatic test_wb_collision();
        int w;
        host_write(3'd1, 32'h11);
        host_write(3'd2, 32'h11);
        do_cmd("collide", OP_ADD, 3'd1, 3'd2, 3'd6, 1'b1, 32'h11, 1'b0, w);
        checks++;
        if (dut.u_regfile.regs[6] !== 32'h22) begin
            failures++;
            $display("FAIL collide_r6 got=%h exp=00000022", dut.u_regfile.regs[6]);
        end
    endtask

    task automatic test_random();
        int w;
        logic [3:0] op;
        for (int i = 0; i < 8; i++) host_write(3'(i), $urandom);
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) host_write(3'($urandom_range(0, 7)), $urandom);
            op = 4'($urandom_range(0, 15));
            do_cmd("random", op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), $urandom, 1'b0, w);
        end
    endtask

    task automatic test_reset_mid();
        host_write(3'd1, 32'h1234);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_ra = 3'd1; cmd_rb = 3'd1; cmd_rd = 3'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || alu_op !== OP_NOP || rsp_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid got done=%b ready=%b op=%h rsp=%h exp=0/1/0/0", done, cmd_ready, alu_op, rsp_data);
        end
        check_regs("reset_mid");
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_done got=%b exp=0", done);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add();
        test_sub_wrap();
        test_illegal();
        test_back_to_back();
        test_wb_collision();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
